serial_subtractor_8bits: RTL and testbench

Multi-cycle 8-bit two's-complement subtractor for the calculator datapath, computing diff = a − b one bit per cycle through a single 1-bit full-subtractor cell. It is the inverse-operation companion of the 8-bit adder and uses the same start/done convention, so the calculator control unit can issue either operation the same way. Signed overflow either forces the result to zero or, when configured, saturates it.

---
 rtl/calc_pkg.sv | 33 +++
 rtl/full_subtractor.sv | 28 ++
 rtl/serial_subtractor_8bits.sv | 124 ++++++++++++
 tb/tb_serial_subtractor_8bits.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/calc_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Package     : calc_pkg                                                   |
// | Description : Shared definitions for the calculator datapath: operand    |
// |               width, the serial-unit FSM state type and the fixed        |
// |               result constants used on signed overflow.                  |
// | Contents    : CALC_WIDTH, state_t (IDLE/RUN/FIN), SAT_POS, SAT_NEG,      |
// |               ZERO, sat_value()                                          |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
package calc_pkg;

  localparam int CALC_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

  localparam logic [CALC_WIDTH-1:0] SAT_POS = 8'h7F;
  localparam logic [CALC_WIDTH-1:0] SAT_NEG = 8'h80;
  localparam logic [CALC_WIDTH-1:0] ZERO    = 8'h00;

  // Clamp value for a signed overflow. Subtraction can only overflow when the
  // operand signs differ, so the minuend sign alone tells the direction:
  // a non-negative minuend overflowed upwards, a negative one downwards.
  function automatic logic [CALC_WIDTH-1:0] sat_value(input logic minuend_msb);
    return minuend_msb ? SAT_NEG : SAT_POS;
  endfunction

endpackage
`default_nettype wire

// File: rtl/full_subtractor.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : full_subtractor                                            |
// | Description : Combinational 1-bit full subtractor, d = a - b - bin.      |
// | Ports       : a    in  1  minuend bit                                    |
// |               b    in  1  subtrahend bit                                 |
// |               bin  in  1  borrow in                                      |
// |               d    out 1  difference bit                                 |
// |               bout out 1  borrow out                                     |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  always_comb begin
    d    = a ^ b ^ bin;
    // Borrow when b exceeds a outright, or when the bits are equal and a
    // borrow is already pending.
    bout = (~a & b) | (~(a ^ b) & bin);
  end

endmodule
`default_nettype wire

// File: rtl/serial_subtractor_8bits.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : serial_subtractor_8bits                                    |
// | Description : Multi-cycle 8-bit two's-complement subtractor, diff = a-b, |
// |               one bit per cycle (LSB first) through a single             |
// |               full_subtractor cell. Same start/done handshake as the     |
// |               serial adder. On signed overflow ovf=1 and diff=0x00, or   |
// |               diff is clamped to 0x7F/0x80 when SUB_SATURATE_EN is       |
// |               defined.                                                   |
// | Ports       : clk   in  1  clock, rising edge                            |
// |               rst   in  1  synchronous active-high reset                 |
// |               start in  1  one-cycle request, samples a and b            |
// |               a     in  8  minuend                                       |
// |               b     in  8  subtrahend                                    |
// |               busy  out 1  operation in progress                         |
// |               done  out 1  one-cycle completion pulse                    |
// |               diff  out 8  result, held until next completion            |
// |               ovf   out 1  signed overflow of last completed operation   |
// | Macros      : SUB_SATURATE_EN - saturate diff on overflow                |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module serial_subtractor_8bits
  import calc_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [CALC_WIDTH-1:0] a,
  input  logic [CALC_WIDTH-1:0] b,
  output logic                  busy,
  output logic                  done,
  output logic [CALC_WIDTH-1:0] diff,
  output logic                  ovf
);

  localparam int WIDTH = CALC_WIDTH;
  localparam int IDX_W = $clog2(WIDTH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

  state_t             r_state;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic [WIDTH-1:0]   r_part;
  logic [IDX_W-1:0]   r_idx;
  logic               r_borrow;

  logic               w_d;
  logic               w_bout;
  logic               w_ovf_calc;
  logic [WIDTH-1:0]   w_ovf_result;

  // The single cell is steered by the bit index.
  full_subtractor u_cell (
    .a    (r_a[r_idx]),
    .b    (r_b[r_idx]),
    .bin  (r_borrow),
    .d    (w_d),
    .bout (w_bout)
  );

  always_comb begin
    // Overflow only when signs differ and the result sign departs from a.
    w_ovf_calc = (r_a[WIDTH-1] ^ r_b[WIDTH-1]) & (r_part[WIDTH-1] ^ r_a[WIDTH-1]);
`ifdef SUB_SATURATE_EN
    w_ovf_result = sat_value(r_a[WIDTH-1]);
`else
    w_ovf_result = ZERO;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_a      <= '0;
      r_b      <= '0;
      r_part   <= '0;
      r_idx    <= '0;
      r_borrow <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      diff     <= ZERO;
      ovf      <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        // Restart from any state; an aborted run leaves diff/ovf untouched.
        r_state  <= RUN;
        r_a      <= a;
        r_b      <= b;
        r_part   <= '0;
        r_idx    <= '0;
        r_borrow <= 1'b0;
        busy     <= 1'b1;
      end else begin
        case (r_state)
          IDLE: begin
            busy <= 1'b0;
          end
          RUN: begin
            r_part[r_idx] <= w_d;
            r_borrow      <= w_bout;
            r_idx         <= r_idx + IDX_W'(1);
            if (r_idx == LAST_IDX) begin
              r_state <= FIN;
            end
          end
          FIN: begin
            diff    <= w_ovf_calc ? w_ovf_result : r_part;
            ovf     <= w_ovf_calc;
            done    <= 1'b1;
            busy    <= 1'b0;
            r_state <= IDLE;
          end
          default: begin
            r_state <= IDLE;
            busy    <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_serial_subtractor_8bits.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_serial_subtractor_8bits                                 |
// | Description : Self-checking bench for serial_subtractor_8bits: directed  |
// |               vector table, restart/reset/back-to-back sequences and     |
// |               random operands against a signed-arithmetic model.         |
// | Macros      : SUB_SATURATE_EN - expectations follow the saturating build |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_serial_subtractor_8bits;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] a;
  logic [7:0] b;
  logic       busy;
  logic       done;
  logic [7:0] diff;
  logic       ovf;

  int tests = 0;
  int fails = 0;

  logic [7:0] prev_diff;
  logic       prev_ovf;

  serial_subtractor_8bits dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .diff  (diff),
    .ovf   (ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] diff;
    logic       ovf;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: true signed difference, then range check.
  task automatic model(input logic [7:0] ma, input logic [7:0] mb,
                       output logic [7:0] md, output logic mo);
    int s;
    s  = int'($signed(ma)) - int'($signed(mb));
    mo = (s > 127) || (s < -128);
    if (mo) begin
`ifdef SUB_SATURATE_EN
      md = (s > 0) ? 8'h7F : 8'h80;
`else
      md = 8'h00;
`endif
    end else begin
      md = s[7:0];
    end
  endtask

  // Called at a negedge: request is sampled on the next posedge; returns at
  // the negedge just after that start edge with start released.
  task automatic launch(input logic [7:0] la, input logic [7:0] lb);
    a = la; b = lb; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a = 8'($urandom); b = 8'($urandom);
  endtask

  // Called at the negedge after the start edge; returns at the done negedge.
  task automatic collect(input string name, input logic [7:0] ed, input logic eo);
    int  k;
    int  busy_n;
    bit  hold_ok;
    k = 0; busy_n = 0; hold_ok = 1'b1;
    while (!done && k < 20) begin
      if (busy) busy_n++;
      if (diff !== prev_diff || ovf !== prev_ovf) hold_ok = 1'b0;
      @(negedge clk);
      k++;
    end
    chk({name, " latency"}, k, 9);
    chk({name, " busy_cycles"}, busy_n, 9);
    chk({name, " result_held"}, hold_ok, 1);
    chk({name, " busy_at_done"}, busy, 0);
    chk({name, " diff"}, diff, ed);
    chk({name, " ovf"}, ovf, eo);
    prev_diff = ed;
    prev_ovf  = eo;
  endtask

  task automatic do_op(input string name, input logic [7:0] oa, input logic [7:0] ob,
                       input logic [7:0] ed, input logic eo);
    @(negedge clk);
    launch(oa, ob);
    collect(name, ed, eo);
    @(negedge clk);
    chk({name, " done_one_cycle"}, done, 0);
  endtask

  task automatic no_done_for(input string name, input int n);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    chk({name, " no_done"}, seen, 0);
  endtask

  initial begin
    logic [7:0] ra, rb, rd, rd2;
    logic       ro, ro2;

    vecs[0] = '{8'h05, 8'h03, 8'h02, 1'b0};
    vecs[1] = '{8'hFB, 8'h03, 8'hF8, 1'b0};
    vecs[2] = '{8'h00, 8'h00, 8'h00, 1'b0};
`ifdef SUB_SATURATE_EN
    vecs[3] = '{8'h64, 8'h9C, 8'h7F, 1'b1};
    vecs[4] = '{8'h80, 8'h01, 8'h80, 1'b1};
`else
    vecs[3] = '{8'h64, 8'h9C, 8'h00, 1'b1};
    vecs[4] = '{8'h80, 8'h01, 8'h00, 1'b1};
`endif
    vecs[5] = '{8'h7F, 8'h7F, 8'h00, 1'b0};

    rst = 1'b1; start = 1'b0; a = 8'h00; b = 8'h00;
    repeat (3) @(negedge clk);
    chk("reset busy", busy, 0);
    chk("reset done", done, 0);
    chk("reset diff", diff, 8'h00);
    chk("reset ovf", ovf, 0);
    rst = 1'b0;
    prev_diff = 8'h00; prev_ovf = 1'b0;

    for (int i = 0; i < 6; i++) begin
      do_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].diff, vecs[i].ovf);
    end

    // Restart: second start 4 cycles after the first.
    @(negedge clk);
    launch(8'h10, 8'h01);
    no_done_for("restart_early", 3);
    launch(8'h20, 8'h02);
    collect("restart", 8'h1E, 1'b0);

    // Back-to-back: new start in the done cycle.
    @(negedge clk);
    launch(8'h40, 8'h01);
    collect("b2b_first", 8'h3F, 1'b0);
    launch(8'h01, 8'h40);
    collect("b2b_second", 8'hC1, 1'b0);
    @(negedge clk);
    chk("b2b done_one_cycle", done, 0);

    // Start held high never completes.
    a = 8'h09; b = 8'h04; start = 1'b1;
    no_done_for("start_held", 15);
    chk("start_held busy", busy, 1);
    start = 1'b0;
    collect("after_hold", 8'h05, 1'b0);

    // Reset mid-operation.
    @(negedge clk);
    launch(8'h33, 8'h11);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst busy", busy, 0);
    chk("midrst done", done, 0);
    chk("midrst diff", diff, 8'h00);
    chk("midrst ovf", ovf, 0);
    prev_diff = 8'h00; prev_ovf = 1'b0;
    no_done_for("midrst", 12);

    // Give the last result a non-zero value, then rst+start together.
    do_op("pre_rst_start", 8'h08, 8'h03, 8'h05, 1'b0);
    rst = 1'b1; start = 1'b1; a = 8'h55; b = 8'h22;
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    chk("rst_start busy", busy, 0);
    chk("rst_start diff", diff, 8'h00);
    prev_diff = 8'h00; prev_ovf = 1'b0;
    no_done_for("rst_start", 12);
    chk("rst_start idle_busy", busy, 0);

    // Random operands, alternating isolated and back-to-back pairs.
    for (int i = 0; i < 40; i++) begin
      ra = 8'($urandom); rb = 8'($urandom);
      if (i % 8 == 0) begin ra = 8'h80; rb = 8'($urandom_range(1, 127)); end
      if (i % 8 == 1) begin ra = 8'($urandom_range(0, 127)); rb = 8'h80; end
      model(ra, rb, rd, ro);
      if (i % 2 == 0) begin
        do_op($sformatf("rnd%0d", i), ra, rb, rd, ro);
      end else begin
        @(negedge clk);
        launch(ra, rb);
        collect($sformatf("rnd%0d", i), rd, ro);
        ra = 8'($urandom); rb = 8'($urandom);
        model(ra, rb, rd2, ro2);
        launch(ra, rb);
        collect($sformatf("rnd%0d_b2b", i), rd2, ro2);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
